// File: rtl/tag_compare_stage.sv
// Tag compare stage: pops one request at a time from the index-extraction FIFO,
// matches it against the returned tag metadata and hands a hit/miss result downstream.
module tag_compare_stage #(
  parameter int unsigned TAG_W   = 54,
  parameter int unsigned IDX_LSB = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  input  logic [80:0]      fifo_data_i,
  input  logic             meta_valid_i,
  output logic             meta_ready_o,
  input  logic [15:0]      meta_id_i,
  input  logic [TAG_W+1:0] meta_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_hit_o,
  output logic             res_dirty_o,
  output logic             res_write_o,
  output logic [15:0]      res_id_o,
  output logic [63:0]      res_addr_o,
  output logic [TAG_W-1:0] res_victim_tag_o,
  output logic             id_err_o,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
);

  // The tag sits directly above the 4-bit set index.
  localparam int unsigned TAG_LSB = IDX_LSB + 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_META = 2'd2,
    OUT       = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic        ent_write_q;
  logic [15:0] ent_id_q;
  logic [63:0] ent_addr_q;

  logic res_hs;
  logic meta_take;
  logic meta_hit;

  assign res_hs    = (state_q == OUT) && res_ready_i;
  assign meta_take = (state_q == WAIT_META) && meta_valid_i;
  assign meta_hit  = meta_data_i[TAG_W+1] &&
                     (meta_data_i[TAG_W-1:0] == ent_addr_q[63:TAG_LSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!fifo_empty_i) state_d = FETCH;
      FETCH:     state_d = WAIT_META;
      WAIT_META: if (meta_valid_i) state_d = OUT;
      OUT: begin
        if (res_ready_i) begin
          state_d = fifo_empty_i ? IDLE : FETCH;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // Pop is qualified by rst_n so the strobe drops with the asynchronous reset.
  always_comb begin
    fifo_rd_en_o = 1'b0;
    meta_ready_o = 1'b0;
    res_valid_o  = 1'b0;
    unique case (state_q)
      IDLE:      fifo_rd_en_o = rst_n && !fifo_empty_i;
      FETCH:     ;
      WAIT_META: meta_ready_o = 1'b1;
      OUT: begin
        res_valid_o  = 1'b1;
        fifo_rd_en_o = rst_n && res_ready_i && !fifo_empty_i;
      end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_write_q <= 1'b0;
      ent_id_q    <= '0;
      ent_addr_q  <= '0;
    end else if (state_q == FETCH) begin
      ent_write_q <= fifo_data_i[80];
      ent_id_q    <= fifo_data_i[79:64];
      ent_addr_q  <= fifo_data_i[63:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_hit_o        <= 1'b0;
      res_dirty_o      <= 1'b0;
      res_write_o      <= 1'b0;
      res_id_o         <= '0;
      res_addr_o       <= '0;
      res_victim_tag_o <= '0;
    end else if (meta_take) begin
      res_hit_o        <= meta_hit;
      res_dirty_o      <= meta_data_i[TAG_W];
      res_write_o      <= ent_write_q;
      res_id_o         <= ent_id_q;
      res_addr_o       <= ent_addr_q;
      res_victim_tag_o <= meta_data_i[TAG_W-1:0];
    end
  end

  // A mismatched id is flagged but the result still goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_err_o <= 1'b0;
    end else if (meta_take && (meta_id_i != ent_id_q)) begin
      id_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (res_hs) begin
      if (res_hit_o) begin
        if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_tag_compare_stage.sv
// Scoreboard bench for tag_compare_stage: FIFO and metadata producers are modelled
// with queues; a negedge monitor checks every presented result against expectations.
module tb_tag_compare_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [80:0] fifo_data = '0;
  logic        meta_valid = 1'b0;
  logic        meta_ready;
  logic [15:0] meta_id = '0;
  logic [55:0] meta_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_hit, res_dirty, res_write;
  logic [15:0] res_id;
  logic [63:0] res_addr;
  logic [53:0] res_vtag;
  logic        id_err;
  logic [31:0] hit_cnt, miss_cnt;

  tag_compare_stage #(.TAG_W(54), .IDX_LSB(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty_i(fifo_empty), .fifo_rd_en_o(fifo_rd_en), .fifo_data_i(fifo_data),
    .meta_valid_i(meta_valid), .meta_ready_o(meta_ready), .meta_id_i(meta_id),
    .meta_data_i(meta_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_hit_o(res_hit),
    .res_dirty_o(res_dirty), .res_write_o(res_write), .res_id_o(res_id),
    .res_addr_o(res_addr), .res_victim_tag_o(res_vtag), .id_err_o(id_err),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic w; logic [15:0] id; logic [63:0] addr; } req_t;
  typedef struct { logic [15:0] id; logic v; logic d; logic [53:0] tag; } meta_t;
  typedef struct {
    logic hit; logic dirty; logic w; logic [15:0] id;
    logic [63:0] addr; logic [53:0] vtag; logic bad_id;
  } exp_t;

  req_t  fifo_q[$];
  meta_t meta_q[$];
  exp_t  sb[$];
  int    pop_cycles[$];

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  bit fast_meta = 1'b1;
  bit meta_pause = 1'b0;
  int ready_mode = 1;          // 0: hold low, 1: hold high, 2: random
  bit err_model = 1'b0;
  int hits_model = 0;
  int miss_model = 0;
  bit res_valid_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Expected outcome comes straight from the address/metadata rules.
  task automatic issue(input logic w, input logic [15:0] id, input logic [63:0] addr,
                       input logic v, input logic d, input logic [53:0] tag,
                       input logic [15:0] mid);
    req_t r; meta_t m; exp_t e;
    r.w = w; r.id = id; r.addr = addr;
    m.id = mid; m.v = v; m.d = d; m.tag = tag;
    e.hit = v && ((addr >> 10) == {10'd0, tag});
    e.dirty = d; e.w = w; e.id = id; e.addr = addr; e.vtag = tag;
    e.bad_id = (mid != id);
    fifo_q.push_back(r);
    meta_q.push_back(m);
    sb.push_back(e);
  endtask

  // Request FIFO: data appears the cycle after the pop, junk otherwise.
  initial begin
    bit pop_now;
    req_t r;
    forever begin
      @(negedge clk);
      pop_now = rst_n && fifo_rd_en;
      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() > 0) begin
        r = fifo_q.pop_front();
        fifo_data = {r.w, r.id, r.addr};
      end else begin
        fifo_data = {17'($urandom), 32'($urandom), 32'($urandom)};
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Metadata producer: once valid, holds until accepted.
  initial begin
    bit taken, held;
    meta_t m;
    forever begin
      @(negedge clk);
      taken = rst_n && meta_valid && meta_ready;
      held = meta_valid && !taken;
      @(posedge clk);
      #1;
      if (taken && meta_q.size() > 0) void'(meta_q.pop_front());
      if (meta_q.size() > 0 && (held || (!meta_pause && (fast_meta || $urandom_range(0, 2) != 0)))) begin
        m = meta_q[0];
        meta_valid = 1'b1;
        meta_id = m.id;
        meta_data = {m.v, m.d, m.tag};
      end else begin
        meta_valid = 1'b0;
        meta_id = 16'($urandom);
        meta_data = {24'($urandom), 32'($urandom)};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: res_ready = 1'b0;
        1: res_ready = 1'b1;
        default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        res_valid_prev = 1'b0;
      end else begin
        check("pop_while_empty", 64'(fifo_rd_en & fifo_empty), 64'(0));
        check("hit_cnt", 64'(hit_cnt), 64'(hits_model));
        check("miss_cnt", 64'(miss_cnt), 64'(miss_model));
        if (res_valid && sb.size() == 0) begin
          check("spurious_result", 64'(res_valid), 64'(0));
        end else if (res_valid) begin
          e = sb[0];
          check("res_hit", 64'(res_hit), 64'(e.hit));
          check("res_dirty", 64'(res_dirty), 64'(e.dirty));
          check("res_write", 64'(res_write), 64'(e.w));
          check("res_id", 64'(res_id), 64'(e.id));
          check("res_addr", res_addr, e.addr);
          check("res_victim_tag", 64'(res_vtag), 64'(e.vtag));
          check("id_err_out", 64'(id_err), 64'(err_model | e.bad_id));
          if (!res_valid_prev && pop_cycles.size() > 0) begin
            lat = cycle - pop_cycles.pop_front();
            if (fast_meta) check("latency", 64'(lat), 64'(3));
          end
          if (res_ready) begin
            check("pop_at_handshake", 64'(fifo_rd_en), 64'(!fifo_empty));
            void'(sb.pop_front());
            err_model = err_model | e.bad_id;
            if (e.hit) hits_model++; else miss_model++;
          end else begin
            check("pop_while_held", 64'(fifo_rd_en), 64'(0));
          end
        end else begin
          check("id_err_idle", 64'(id_err), 64'(err_model));
          check("meta_ready_only_waiting", 64'(meta_ready & fifo_rd_en), 64'(0));
        end
        if (fifo_rd_en) pop_cycles.push_back(cycle);
        res_valid_prev = res_valid;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 3000 && (sb.size() != 0 || fifo_q.size() != 0); i++) @(posedge clk);
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd_en"}, 64'(fifo_rd_en), 64'(0));
    check({name, "_meta_ready"}, 64'(meta_ready), 64'(0));
    check({name, "_res_valid"}, 64'(res_valid), 64'(0));
    check({name, "_id_err"}, 64'(id_err), 64'(0));
    check({name, "_res_data"}, 64'({res_hit, res_dirty, res_write, res_id}) | res_addr | 64'(res_vtag), 64'(0));
    check({name, "_counters"}, {hit_cnt, miss_cnt}, 64'(0));
  endtask

  initial begin
    logic [63:0] a;
    logic [53:0] t;
    logic [15:0] id, mid;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("empty_no_pop", 64'(fifo_rd_en), 64'(0));

    // Write hit, read miss with dirty victim, invalid line with matching tag
    issue(1'b1, 16'h0003, 64'h1A40, 1'b1, 1'b0, 54'h6, 16'h0003);
    drain();
    check("write_hit_cnt", 64'(hit_cnt), 64'(1));
    issue(1'b0, 16'h0007, 64'h1A40, 1'b1, 1'b1, 54'h9, 16'h0007);
    drain();
    check("dirty_miss_cnt", 64'(miss_cnt), 64'(1));
    issue(1'b0, 16'h0008, 64'h1A40, 1'b0, 1'b0, 54'h6, 16'h0008);
    drain();
    check("invalid_miss_cnt", 64'(miss_cnt), 64'(2));

    // Backpressure on the first of three queued results
    ready_mode = 0;
    for (int i = 0; i < 3; i++)
      issue(i[0], 16'(16'h0010 + i), 64'h0000_0000_0000_1A40 + 64'(i * 64'h400), 1'b1, 1'b0, 54'(6 + i), 16'(16'h0010 + i));
    for (int i = 0; i < 200 && !res_valid; i++) @(negedge clk);
    check("bp_result_seen", 64'(res_valid), 64'(1));
    repeat (5) @(negedge clk);
    ready_mode = 1;
    drain();

    // Id mismatch, then correct transactions
    issue(1'b0, 16'h0002, 64'h2000, 1'b1, 1'b0, 54'h8, 16'h0005);
    issue(1'b1, 16'h0020, 64'h2400, 1'b1, 1'b0, 54'h9, 16'h0020);
    issue(1'b0, 16'h0021, 64'h2800, 1'b1, 1'b1, 54'h3, 16'h0021);
    drain();
    check("id_err_sticky", 64'(id_err), 64'(1));

    // Randomized traffic
    fast_meta = 1'b0;
    ready_mode = 2;
    for (int n = 0; n < 60; n++) begin
      a = {$urandom, $urandom};
      id = 16'($urandom);
      mid = ($urandom_range(0, 7) == 0) ? ~id : id;
      t = ($urandom_range(0, 1) == 1) ? a[63:10] : 54'({$urandom, $urandom});
      issue(1'($urandom), id, a, ($urandom_range(0, 3) != 0), 1'($urandom), t, mid);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #2;
    end
    drain();
    ready_mode = 1;
    fast_meta = 1'b1;

    // Reset while waiting for metadata
    meta_pause = 1'b1;
    issue(1'b1, 16'h0BAD, 64'h1A40, 1'b1, 1'b0, 54'h6, 16'h0BAD);
    for (int i = 0; i < 50 && !meta_ready; i++) @(negedge clk);
    check("reached_wait_meta", 64'(meta_ready), 64'(1));
    #1;
    rst_n = 1'b0;
    sb.delete(); fifo_q.delete(); meta_q.delete(); pop_cycles.delete();
    err_model = 1'b0; hits_model = 0; miss_model = 0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    meta_pause = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    issue(1'b0, 16'h0044, 64'h1A40, 1'b1, 1'b1, 54'h6, 16'h0044);
    drain();
    check("restart_hit_cnt", 64'(hit_cnt), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", compared);
    $fatal(1, "watchdog expired");
  end

endmodule
